// File: rtl/timer_counter_core.sv
// Programmable timer core: prescaled up-counter with periodic/one-shot expiry,
// pause/resume, restart, and a sticky, maskable interrupt.
module timer_counter_core #(
    parameter int CNT_W = 32,
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [CNT_W-1:0] cnt_max_value,
    input  logic             enable,
    input  logic             one_shot,
    input  logic [PSC_W-1:0] prescale,
    input  logic             cnt_load,
    input  logic             irq_en,
    input  logic             irq_clr,
    output logic [CNT_W-1:0] cnt_value,
    output logic             expired,
    output logic             irq,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PSC_W-1:0] psc;
    logic [PSC_W-1:0] psc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             expired_next;
    logic             irq_pend;
    logic             tick;
    logic             at_max;

    // A RUN cycle with enable low is the pause edge itself, so it never ticks.
    assign tick   = (state == RUN) && enable && (psc == prescale);
    assign at_max = (cnt_value >= cnt_max_value);

    always_comb begin
        state_next   = state;
        psc_next     = psc;
        cnt_next     = cnt_value;
        expired_next = 1'b0;
        if (cnt_load) begin
            cnt_next   = '0;
            psc_next   = '0;
            state_next = enable ? RUN : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_next = IDLE;
                    end else if (tick) begin
                        psc_next = '0;
                        if (!at_max) begin
                            cnt_next = cnt_value + CNT_W'(1);
                        end else begin
                            expired_next = 1'b1;
                            if (one_shot) begin
                                state_next = DONE;
                            end else begin
                                cnt_next = '0;
                            end
                        end
                    end else begin
                        psc_next = psc + PSC_W'(1);
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            psc       <= '0;
            cnt_value <= '0;
            expired   <= 1'b0;
        end else begin
            state     <= state_next;
            psc       <= psc_next;
            cnt_value <= cnt_next;
            expired   <= expired_next;
        end
    end

    // Setting wins over a coincident clear so no expiry is ever lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_pend <= 1'b0;
        end else if (expired) begin
            irq_pend <= 1'b1;
        end else if (irq_clr) begin
            irq_pend <= 1'b0;
        end
    end

    assign irq     = irq_pend & irq_en;
    assign state_o = state;

endmodule

// File: tb/tb_timer_counter_core.sv
// Self-checking bench for timer_counter_core: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_timer_counter_core;

    localparam int CNT_W = 8;
    localparam int PSC_W = 3;

    logic             clk;
    logic             rstn;
    logic [CNT_W-1:0] cnt_max_value;
    logic             enable;
    logic             one_shot;
    logic [PSC_W-1:0] prescale;
    logic             cnt_load;
    logic             irq_en;
    logic             irq_clr;
    logic [CNT_W-1:0] cnt_value;
    logic             expired;
    logic             irq;
    logic [1:0]       state_o;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 running, 2 done
    int m_state;
    int m_cnt;
    int m_psc;
    int m_exp;
    int m_pend;

    timer_counter_core #(.CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cnt_max_value(cnt_max_value),
        .enable       (enable),
        .one_shot     (one_shot),
        .prescale     (prescale),
        .cnt_load     (cnt_load),
        .irq_en       (irq_en),
        .irq_clr      (irq_clr),
        .cnt_value    (cnt_value),
        .expired      (expired),
        .irq          (irq),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_state = 0;
        m_cnt   = 0;
        m_psc   = 0;
        m_exp   = 0;
        m_pend  = 0;
    endtask

    // One clock edge of timer behaviour, using the inputs present at the edge.
    task automatic modelStep();
        int new_exp;
        if (!rstn) begin
            modelReset();
            return;
        end
        new_exp = 0;
        if (m_exp != 0) m_pend = 1;
        else if (irq_clr) m_pend = 0;
        if (cnt_load) begin
            m_cnt   = 0;
            m_psc   = 0;
            m_state = enable ? 1 : 0;
        end else if (m_state == 0) begin
            if (enable) m_state = 1;
        end else if (m_state == 1) begin
            if (!enable) begin
                m_state = 0;
            end else if (m_psc == int'(prescale)) begin
                m_psc = 0;
                if (m_cnt < int'(cnt_max_value)) begin
                    m_cnt = m_cnt + 1;
                end else begin
                    new_exp = 1;
                    if (one_shot) m_state = 2;
                    else m_cnt = 0;
                end
            end else begin
                m_psc = (m_psc + 1) % (1 << PSC_W);
            end
        end
        m_exp = new_exp;
    endtask

    task automatic checkOutput();
        checkVal("cnt_value", int'(cnt_value), m_cnt);
        checkVal("expired", int'(expired), m_exp);
        checkVal("irq", int'(irq), m_pend & int'(irq_en));
        checkVal("state_o", int'(state_o), m_state);
    endtask

    // Called at a falling edge with inputs already set; ends at the next falling edge.
    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic runCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus();
    endtask

    task automatic doReset();
        rstn = 1'b0;
        #1;
        modelReset();
        checkVal("reset_cnt", int'(cnt_value), 0);
        checkVal("reset_state", int'(state_o), 0);
        checkVal("reset_expired", int'(expired), 0);
        checkVal("reset_irq", int'(irq), 0);
        applyStimulus();
        rstn = 1'b1;
    endtask

    task automatic setup(input int mx, input int psc, input bit os);
        cnt_max_value = CNT_W'(mx);
        prescale      = PSC_W'(psc);
        one_shot      = os;
        enable        = 1'b1;
        cnt_load      = 1'b0;
        irq_clr       = 1'b0;
        irq_en        = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        setup(0, 0, 1'b0);
        enable = 1'b0;
        modelReset();
        @(negedge clk);

        // Periodic count 0..3 with expiry and interrupt collision handling
        doReset();
        setup(3, 0, 1'b0);
        runCycles(4);
        checkVal("periodic_cnt3", int'(cnt_value), 3);
        runCycles(1);
        checkVal("periodic_expired", int'(expired), 1);
        checkVal("periodic_wrap", int'(cnt_value), 0);
        runCycles(1);
        checkVal("periodic_irq", int'(irq), 1);
        checkVal("periodic_exp_pulse", int'(expired), 0);
        runCycles(3);
        checkVal("second_expired", int'(expired), 1);
        irq_clr = 1'b1;
        runCycles(1);
        checkVal("collision_irq", int'(irq), 1);
        irq_clr = 1'b0;
        runCycles(1);
        irq_clr = 1'b1;
        runCycles(1);
        checkVal("lone_clr_irq", int'(irq), 0);
        irq_clr = 1'b0;

        // One-shot with prescaler: a tick every five cycles, expiry at the third
        doReset();
        setup(2, 4, 1'b1);
        runCycles(6);
        checkVal("oneshot_first_tick", int'(cnt_value), 1);
        runCycles(9);
        checkVal("oneshot_cnt2", int'(cnt_value), 2);
        checkVal("oneshot_no_exp_yet", int'(expired), 0);
        runCycles(1);
        checkVal("oneshot_expired", int'(expired), 1);
        checkVal("oneshot_done", int'(state_o), 2);
        checkVal("oneshot_hold", int'(cnt_value), 2);
        enable = 1'b0;
        runCycles(3);
        checkVal("done_ignores_enable", int'(state_o), 2);
        cnt_load = 1'b1;
        runCycles(1);
        checkVal("load_to_idle", int'(state_o), 0);
        checkVal("load_clears_cnt", int'(cnt_value), 0);
        cnt_load = 1'b0;

        // Pause at 5 for ten cycles, then resume at 6
        doReset();
        setup(100, 0, 1'b0);
        runCycles(6);
        checkVal("pause_at5", int'(cnt_value), 5);
        enable = 1'b0;
        runCycles(10);
        checkVal("paused_cnt", int'(cnt_value), 5);
        checkVal("paused_state", int'(state_o), 0);
        enable = 1'b1;
        runCycles(2);
        checkVal("resume_cnt6", int'(cnt_value), 6);

        // Restart coinciding with the terminal tick suppresses the expiry
        doReset();
        setup(2, 0, 1'b0);
        runCycles(3);
        checkVal("load_pre_cnt", int'(cnt_value), 2);
        cnt_load = 1'b1;
        runCycles(1);
        checkVal("load_tick_cnt", int'(cnt_value), 0);
        checkVal("load_tick_noexp", int'(expired), 0);
        checkVal("load_tick_state", int'(state_o), 1);
        cnt_load = 1'b0;
        runCycles(1);
        checkVal("load_tick_irq", int'(irq), 0);

        // Lowering the terminal count below the current value
        doReset();
        setup(20, 0, 1'b0);
        runCycles(11);
        checkVal("lower_pre_cnt", int'(cnt_value), 10);
        cnt_max_value = CNT_W'(4);
        runCycles(1);
        checkVal("lower_expired", int'(expired), 1);
        checkVal("lower_cnt0", int'(cnt_value), 0);

        // Zero terminal count expires on every tick
        doReset();
        setup(0, 1, 1'b0);
        runCycles(3);
        checkVal("max0_expired", int'(expired), 1);
        checkVal("max0_cnt", int'(cnt_value), 0);

        // Randomized traffic against the model
        doReset();
        setup(5, 1, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) one_shot = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 20) == 0) prescale = PSC_W'($urandom_range(0, 7));
            if ($urandom_range(0, 10) == 0) begin
                if ($urandom_range(0, 15) == 0) cnt_max_value = CNT_W'(255);
                else cnt_max_value = CNT_W'($urandom_range(0, 12));
            end
            cnt_load = ($urandom_range(0, 40) == 0);
            irq_clr  = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 15) == 0) irq_en = ~irq_en;
            if ($urandom_range(0, 500) == 0) doReset();
            else applyStimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
